// File: rtl/onehot_pulse_decoder_if.sv
// Encoded-index handshake bus feeding onehot_pulse_decoder.
// master drives code_in/code_valid, slave answers with code_ready.
interface onehot_pulse_decoder_if #(
    parameter int CODE_W = 2
);
    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic              code_ready;

    modport master (
        output code_in,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: buffers encoded indices in a small FIFO and replays each
// one as a fixed-width one-hot pulse followed by a fixed all-zero gap.
// Optional feature: define ONEHOT_HIST_EN to add per-code saturating pop
// counters readable through hist_sel/hist_cnt.
module onehot_pulse_decoder #(
    parameter int CODE_W       = 2,
    parameter int PULSE_CYCLES = 3,
    parameter int GAP_CYCLES   = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int OUT_W       = 2 ** CODE_W,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_pulse_decoder_if.slave code_bus,
    output logic [OUT_W-1:0]      onehot_out,
    output logic                  strobe,
    output logic                  busy,
    output logic [LVL_W-1:0]      fifo_level
`ifdef ONEHOT_HIST_EN
    ,
    input  logic [CODE_W-1:0]     hist_sel,
    output logic [7:0]            hist_cnt
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              pulse_end;
    logic              gap_end;
    logic [CODE_W-1:0] head;

    assign full                = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty               = (fifo_level == '0);
    assign code_bus.code_ready = !full;
    assign push                = code_bus.code_valid && !full;
    assign head                = mem[rd_ptr];
    assign busy                = (state != IDLE) || !empty;

    // Decide whether the FSM takes the FIFO head this cycle.
    always_comb begin
        pulse_end = (state == DRIVE) && (cnt == PULSE_LAST);
        gap_end   = (state == GAP) && (cnt == GAP_LAST);
        pop       = 1'b0;
        if (!empty) begin
            if (state == IDLE || gap_end) begin
                pop = 1'b1;
            end else if (pulse_end && GAP_CYCLES == 0) begin
                // With no gap the pulse end is itself the reload point.
                pop = 1'b1;
            end
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= code_bus.code_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Pulse/gap sequencer with registered one-hot and strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            onehot_out <= '0;
            strobe     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        onehot_out <= OUT_W'(1) << head;
                        strobe     <= 1'b1;
                        cnt        <= '0;
                        state      <= DRIVE;
                    end else begin
                        onehot_out <= '0;
                        strobe     <= 1'b0;
                    end
                end
                DRIVE: begin
                    strobe <= 1'b0;
                    if (pulse_end) begin
                        cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            onehot_out <= '0;
                            state      <= GAP;
                        end else if (pop) begin
                            onehot_out <= OUT_W'(1) << head;
                            strobe     <= 1'b1;
                            state      <= DRIVE;
                        end else begin
                            onehot_out <= '0;
                            state      <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    strobe <= 1'b0;
                    if (gap_end) begin
                        cnt <= '0;
                        if (pop) begin
                            onehot_out <= OUT_W'(1) << head;
                            strobe     <= 1'b1;
                            state      <= DRIVE;
                        end else begin
                            onehot_out <= '0;
                            state      <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    onehot_out <= '0;
                    strobe     <= 1'b0;
                end
            endcase
        end
    end

`ifdef ONEHOT_HIST_EN
    logic [7:0] hist [OUT_W];

    // Per-code pop counters that saturate at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < OUT_W; i++) begin
                hist[i] <= '0;
            end
        end else if (pop && hist[head] != 8'hFF) begin
            hist[head] <= hist[head] + 8'd1;
        end
    end

    assign hist_cnt = hist[hist_sel];
`endif

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder with default parameters
// (CODE_W=2, PULSE_CYCLES=3, GAP_CYCLES=1, FIFO_DEPTH=4).
module tb_onehot_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] onehot_out;
    logic       strobe;
    logic       busy;
    logic [2:0] fifo_level;
`ifdef ONEHOT_HIST_EN
    logic [1:0] hist_sel;
    logic [7:0] hist_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_pat [8];

    always #5 clk = ~clk;

    onehot_pulse_decoder_if #(.CODE_W(2)) code_bus ();

    onehot_pulse_decoder #(
        .CODE_W      (2),
        .PULSE_CYCLES(3),
        .GAP_CYCLES  (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_bus  (code_bus),
        .onehot_out(onehot_out),
        .strobe    (strobe),
        .busy      (busy),
        .fifo_level(fifo_level)
`ifdef ONEHOT_HIST_EN
        ,
        .hist_sel  (hist_sel),
        .hist_cnt  (hist_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] oh, input logic st);
        check_eq({tag, "_onehot"}, 32'(onehot_out), 32'(oh));
        check_eq({tag, "_strobe"}, 32'(strobe), 32'(st));
    endtask

    // Checks n pulse periods (3 drive cycles + 1 gap) starting at the next edge.
    task automatic expect_train(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check_out($sformatf("%s_p%0d_c%0d", tag, k, c),
                          (c < 3) ? exp_pat[k] : 4'b0000, c == 0);
            end
        end
    endtask

`ifdef ONEHOT_HIST_EN
    task automatic push_code(input logic [1:0] c);
        bit done = 1'b0;
        code_bus.code_in    = c;
        code_bus.code_valid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            if (code_bus.code_ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        code_bus.code_valid = 1'b0;
        check_eq("hist_push_accepted", 32'(done), 32'd1);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ONEHOT_HIST_EN
        hist_sel = 2'd0;
`endif
        // 1: reset with valid held high
        rst_n               = 1'b0;
        code_bus.code_in    = 2'd2;
        code_bus.code_valid = 1'b1;
        tick();
        tick();
        check_out("rst", 4'b0000, 1'b0);
        check_eq("rst_ready", 32'(code_bus.code_ready), 32'd1);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        code_bus.code_valid = 1'b0;
        rst_n               = 1'b1;
        tick();
        check_eq("post_rst_level", 32'(fifo_level), 32'd0);

        // 2: single code 2
        code_bus.code_in    = 2'd2;
        code_bus.code_valid = 1'b1;
        tick();
        code_bus.code_valid = 1'b0;
        check_eq("t2_level_push", 32'(fifo_level), 32'd1);
        check_eq("t2_busy_push", 32'(busy), 32'd1);
        check_out("t2_push", 4'b0000, 1'b0);
        tick(); check_out("t2_c0", 4'b0100, 1'b1);
        check_eq("t2_level_pop", 32'(fifo_level), 32'd0);
        tick(); check_out("t2_c1", 4'b0100, 1'b0);
        tick(); check_out("t2_c2", 4'b0100, 1'b0);
        tick(); check_out("t2_gap", 4'b0000, 1'b0);
        check_eq("t2_busy_gap", 32'(busy), 32'd1);
        tick(); check_out("t2_idle", 4'b0000, 1'b0);
        check_eq("t2_busy_idle", 32'(busy), 32'd0);

        // 3: back-to-back 3,0,1,2
        exp_pat[0] = 4'b1000; exp_pat[1] = 4'b0001;
        exp_pat[2] = 4'b0010; exp_pat[3] = 4'b0100;
        fork
            begin
                logic [1:0] seq [4];
                int         lvl [4];
                seq = '{2'd3, 2'd0, 2'd1, 2'd2};
                lvl = '{1, 1, 2, 3};
                for (int i = 0; i < 4; i++) begin
                    code_bus.code_in    = seq[i];
                    code_bus.code_valid = 1'b1;
                    tick();
                    check_eq($sformatf("t3_level%0d", i), 32'(fifo_level), 32'(lvl[i]));
                    check_eq($sformatf("t3_ready%0d", i), 32'(code_bus.code_ready), 32'd1);
                end
                code_bus.code_valid = 1'b0;
            end
            begin
                tick();
                check_out("t3_lat", 4'b0000, 1'b0);
                expect_train("t3", 4);
            end
        join
        tick();
        check_eq("t3_busy_end", 32'(busy), 32'd0);

        // 4: fill to full, hold code 1 while full, pointer wrap
        exp_pat[0] = 4'b0100; exp_pat[1] = 4'b1000; exp_pat[2] = 4'b0001;
        exp_pat[3] = 4'b0100; exp_pat[4] = 4'b1000; exp_pat[5] = 4'b0010;
        fork
            begin
                logic [1:0] seq [5];
                int         lvl [5];
                seq = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
                lvl = '{1, 1, 2, 3, 4};
                for (int i = 0; i < 5; i++) begin
                    code_bus.code_in    = seq[i];
                    code_bus.code_valid = 1'b1;
                    tick();
                    check_eq($sformatf("t4_level%0d", i), 32'(fifo_level), 32'(lvl[i]));
                end
                check_eq("t4_ready_full", 32'(code_bus.code_ready), 32'd0);
                code_bus.code_in = 2'd1;
                tick();
                check_eq("t4_level_blocked", 32'(fifo_level), 32'd3);
                check_eq("t4_ready_reopen", 32'(code_bus.code_ready), 32'd1);
                tick();
                check_eq("t4_level_refill", 32'(fifo_level), 32'd4);
                check_eq("t4_ready_refull", 32'(code_bus.code_ready), 32'd0);
                code_bus.code_valid = 1'b0;
            end
            begin
                tick();
                check_out("t4_lat", 4'b0000, 1'b0);
                expect_train("t4", 6);
            end
        join
        tick();
        check_eq("t4_busy_end", 32'(busy), 32'd0);
        check_eq("t4_level_end", 32'(fifo_level), 32'd0);

        // 5: reset in the second drive cycle with two codes queued
        for (int i = 0; i < 3; i++) begin
            code_bus.code_in    = 2'(i + 1);
            code_bus.code_valid = 1'b1;
            tick();
        end
        code_bus.code_valid = 1'b0;
        check_out("t5_pre", 4'b0010, 1'b0);
        check_eq("t5_pre_level", 32'(fifo_level), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_out("t5_rst", 4'b0000, 1'b0);
        check_eq("t5_rst_level", 32'(fifo_level), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check_eq($sformatf("t5_quiet%0d", c), 32'(onehot_out), 32'd0);
        end
        check_eq("t5_quiet_level", 32'(fifo_level), 32'd0);

`ifdef ONEHOT_HIST_EN
        // 6: histogram saturation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 260; i++) push_code(2'd0);
        for (int i = 0; i < 2; i++) push_code(2'd3);
        for (int w = 0; w < 2000; w++) begin
            if (!busy) break;
            tick();
        end
        check_eq("t6_drain", 32'(busy), 32'd0);
        begin
            int exp_h [4];
            exp_h = '{255, 0, 0, 2};
            for (int s = 0; s < 4; s++) begin
                hist_sel = 2'(s);
                #1;
                check_eq($sformatf("t6_hist%0d", s), 32'(hist_cnt), 32'(exp_h[s]));
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
